// File: rtl/sample_deserializer_pkg.sv
// Shared types and configuration constants for the sample deserializer.
package sample_deserializer_pkg;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  localparam int N_LEGAL = 4;
  localparam int LEGAL_N_SAMPLES [N_LEGAL] = '{2, 4, 8, 16};

  function automatic logic is_legal_n_samples(input int n);
    logic ok_s;
    ok_s = 1'b0;
    for (int i = 0; i < N_LEGAL; i++) begin
      if (LEGAL_N_SAMPLES[i] == n) begin
        ok_s = 1'b1;
      end else begin
        ok_s = ok_s;
      end
    end
    return ok_s;
  endfunction

endpackage

// File: rtl/sample_deserializer_if.sv
// Serial-sample input and parallel-frame output of the deserializer.
interface sample_deserializer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
) ();

  logic [BIT_WIDTH-1:0] recv_msg;
  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES];
  logic                 send_val;
  logic                 send_rdy;

  // master is the deserializer; slave is the producer/FFT pair around it
  modport master (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val
  );

  modport slave (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val
  );

endinterface

// File: rtl/sample_deserializer_chk.sv
// Configuration and handshake properties for the sample deserializer.
module sample_deserializer_chk
  import sample_deserializer_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int N_SAMPLES  = 8,
  parameter int DECIMAL_PT = 16
) (
  input logic clk,
  input logic reset,
  input logic send_val,
  input logic send_rdy,
  input logic recv_rdy
);

  a_legal_cfg: assert property (@(posedge clk) disable iff (!reset)
    is_legal_n_samples(N_SAMPLES) && (DECIMAL_PT >= 0) && (DECIMAL_PT <= BIT_WIDTH));

  a_collect_rdy: assert property (@(posedge clk) disable iff (!reset)
    !send_val |-> recv_rdy);

  a_full_rdy: assert property (@(posedge clk) disable iff (!reset)
    send_val |-> (recv_rdy == send_rdy));

endmodule

// File: rtl/sample_deserializer_frame_counter.sv
// Write-slot counter that wraps at N; inc wins over clr.
module frame_counter #(
  parameter int N  = 8,
  parameter int CW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next_s;

  // Next count: advance on inc, wrapping after the last slot
  always_comb begin
    count_next_s = count_r;
    if (inc) begin
      if (count_r == LAST) begin
        count_next_s = {CW{1'b0}};
      end else begin
        count_next_s = count_r + CW'(1);
      end
    end else if (clr) begin
      count_next_s = {CW{1'b0}};
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count = count_r;
  assign wrap  = (count_r == LAST);

endmodule

// File: rtl/sample_deserializer.sv
// Collects N_SAMPLES serial fixed-point samples into one parallel frame for the FFT.
// A pending frame may be replaced in the same edge it leaves, so streaming has no bubbles.
module sample_deserializer
  import sample_deserializer_pkg::*;
#(
  parameter int BIT_WIDTH  = 32,
  parameter int N_SAMPLES  = 8,
  parameter int DECIMAL_PT = 16
) (
  input logic                   clk,
  input logic                   reset,
  sample_deserializer_if.master bus
);

  localparam int CW = $clog2(N_SAMPLES);

  state_e               state_r;
  state_e               state_next_s;
  logic [CW-1:0]        count_s;
  logic                 last_s;
  logic                 recv_rdy_s;
  logic                 send_val_s;
  logic                 recv_fire_s;
  logic                 send_fire_s;
  logic [BIT_WIDTH-1:0] buffer_r [N_SAMPLES];

  // In FULL a new sample may only enter when the current frame leaves
  assign recv_rdy_s  = (state_r == FULL) ? bus.send_rdy : 1'b1;
  assign send_val_s  = (state_r == FULL);
  assign recv_fire_s = bus.recv_val && recv_rdy_s;
  assign send_fire_s = send_val_s && bus.send_rdy;

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      COLLECT: begin
        if (recv_fire_s && last_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = COLLECT;
        end
      end
      FULL: begin
        if (send_fire_s) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = COLLECT;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= COLLECT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Sample buffer; count is already 0 in FULL, so an overlapping sample lands in slot 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        buffer_r[i] <= {BIT_WIDTH{1'b0}};
      end
    end else if (recv_fire_s) begin
      buffer_r[count_s] <= bus.recv_msg;
    end
  end

  frame_counter #(
    .N  (N_SAMPLES),
    .CW (CW)
  ) u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (send_fire_s && !recv_fire_s),
    .inc   (recv_fire_s),
    .count (count_s),
    .wrap  (last_s)
  );

  sample_deserializer_chk #(
    .BIT_WIDTH  (BIT_WIDTH),
    .N_SAMPLES  (N_SAMPLES),
    .DECIMAL_PT (DECIMAL_PT)
  ) u_chk (
    .clk      (clk),
    .reset    (reset),
    .send_val (send_val_s),
    .send_rdy (bus.send_rdy),
    .recv_rdy (recv_rdy_s)
  );

  assign bus.recv_rdy = recv_rdy_s;
  assign bus.send_val = send_val_s;
  assign bus.send_msg = buffer_r;

endmodule

// File: tb/tb_sample_deserializer.sv
// Directed bench for sample_deserializer: an 8-sample instance and a 2-sample instance
// share clock and reset; inputs change 1 ns after the rising edge and are checked there.
module tb_sample_deserializer;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [31:0] exp8 [8];
  logic [31:0] vals [16];
  logic        rdy_low;

  always #5 clk = ~clk;

  sample_deserializer_if #(.BIT_WIDTH(32), .N_SAMPLES(8)) bus8 ();
  sample_deserializer_if #(.BIT_WIDTH(32), .N_SAMPLES(2)) bus2 ();

  sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(8), .DECIMAL_PT(16)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  sample_deserializer #(.BIT_WIDTH(32), .N_SAMPLES(2), .DECIMAL_PT(16)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_frame8(input string tag, input logic [31:0] exp [8]);
    for (int k = 0; k < 8; k++) begin
      check_eq($sformatf("%s[%0d]", tag, k), bus8.send_msg[k], exp[k]);
    end
  endtask

  initial begin
    vals = '{32'hFFFF0000, 32'h7FFFFFFF, 32'h80000000, 32'h00000001,
             32'hFFFFFFFF, 32'h12345678, 32'h80000001, 32'h0000FFFF,
             32'hFFFFFFFE, 32'h11111111, 32'h00000000, 32'h22222222,
             32'hC0000000, 32'h33333333, 32'h7FFF8000, 32'h44444444};
    reset         = 1'b0;
    bus8.recv_msg = 32'd0;
    bus8.recv_val = 1'b0;
    bus8.send_rdy = 1'b0;
    bus2.recv_msg = 32'd0;
    bus2.recv_val = 1'b0;
    bus2.send_rdy = 1'b0;

    // Reset state, before any clock edge
    #2;
    check_eq("rst_send_val", 32'(bus8.send_val), 32'd0);
    check_eq("rst_recv_rdy", 32'(bus8.recv_rdy), 32'd1);
    check_eq("rst_buf0", bus8.send_msg[0], 32'd0);
    check_eq("rst_n2_send_val", 32'(bus2.send_val), 32'd0);
    #10 reset = 1'b1;
    #1;

    // One frame 1..8, first edge after release accepts sample 1
    bus8.send_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus8.recv_msg = 32'(i);
      bus8.recv_val = 1'b1;
      step();
      if (i == 7) check_eq("t1_no_early_val", 32'(bus8.send_val), 32'd0);
    end
    check_eq("t1_send_val", 32'(bus8.send_val), 32'd1);
    for (int k = 0; k < 8; k++) exp8[k] = 32'(k + 1);
    check_frame8("t1_frame", exp8);
    bus8.recv_val = 1'b0;
    step();
    check_eq("t1_consumed", 32'(bus8.send_val), 32'd0);

    // Continuous stream 1..16, two back-to-back frames
    rdy_low = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      bus8.recv_msg = 32'(i);
      bus8.recv_val = 1'b1;
      #1;
      if (!bus8.recv_rdy) rdy_low = 1'b1;
      step();
      check_eq($sformatf("t2_val_%0d", i), 32'(bus8.send_val), 32'((i == 8) || (i == 16)));
      if (i == 8) begin
        for (int k = 0; k < 8; k++) exp8[k] = 32'(k + 1);
        check_frame8("t2_frame_a", exp8);
      end
      if (i == 16) begin
        for (int k = 0; k < 8; k++) exp8[k] = 32'(k + 9);
        check_frame8("t2_frame_b", exp8);
      end
    end
    check_eq("t2_rdy_never_low", 32'(rdy_low), 32'd0);
    bus8.recv_val = 1'b0;
    step();
    check_eq("t2_consumed", 32'(bus8.send_val), 32'd0);

    // Backpressure: frame held for 5 cycles while upstream keeps offering
    bus8.send_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus8.recv_msg = 32'(32'hA0 + i);
      bus8.recv_val = 1'b1;
      step();
    end
    check_eq("t3_send_val", 32'(bus8.send_val), 32'd1);
    bus8.recv_msg = 32'hDEADBEEF;
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("t3_rdy_low_%0d", c), 32'(bus8.recv_rdy), 32'd0);
      check_eq($sformatf("t3_hold0_%0d", c), bus8.send_msg[0], 32'hA1);
      check_eq($sformatf("t3_hold7_%0d", c), bus8.send_msg[7], 32'hA8);
      step();
    end
    bus8.send_rdy = 1'b1;
    bus8.recv_val = 1'b0;
    #1;
    check_eq("t3_rdy_same_cycle", 32'(bus8.recv_rdy), 32'd1);
    step();
    check_eq("t3_consumed", 32'(bus8.send_val), 32'd0);
    check_eq("t3_no_capture", bus8.send_msg[0], 32'hA1);

    // Mid-frame asynchronous reset, then a clean frame
    bus8.send_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      bus8.recv_msg = 32'(32'h55 + i);
      bus8.recv_val = 1'b1;
      step();
    end
    bus8.recv_val = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_eq("t4_send_val", 32'(bus8.send_val), 32'd0);
    check_eq("t4_recv_rdy", 32'(bus8.recv_rdy), 32'd1);
    check_eq("t4_buf0_clr", bus8.send_msg[0], 32'd0);
    check_eq("t4_buf4_clr", bus8.send_msg[4], 32'd0);
    #2 reset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      bus8.recv_msg = 32'(32'h10000 * i);
      bus8.recv_val = 1'b1;
      step();
    end
    check_eq("t4_frame_val", 32'(bus8.send_val), 32'd1);
    for (int k = 0; k < 8; k++) exp8[k] = 32'(32'h10000 * (k + 1));
    check_frame8("t4_frame", exp8);

    // Reset while FULL drops the pending frame
    bus8.recv_val = 1'b0;
    #3 reset = 1'b0;
    #1;
    check_eq("t4_full_reset", 32'(bus8.send_val), 32'd0);
    check_eq("t4_full_buf", bus8.send_msg[0], 32'd0);
    #1 reset = 1'b1;
    bus8.send_rdy = 1'b1;
    step();
    check_eq("t4_no_pending", 32'(bus8.send_val), 32'd0);

    // recv_val toggling: only handshaked samples captured, bit-exact
    bus8.send_rdy = 1'b0;
    for (int i = 0; i <= 14; i++) begin
      bus8.recv_msg = vals[i];
      bus8.recv_val = ((i % 2) == 0);
      step();
      if (i == 12) check_eq("t5_not_full_yet", 32'(bus8.send_val), 32'd0);
    end
    check_eq("t5_send_val", 32'(bus8.send_val), 32'd1);
    for (int k = 0; k < 8; k++) exp8[k] = vals[2 * k];
    check_frame8("t5_frame", exp8);
    bus8.recv_val = 1'b0;
    bus8.send_rdy = 1'b1;
    step();
    check_eq("t5_consumed", 32'(bus8.send_val), 32'd0);

    // Two-sample instance: 3,4,5,6 -> [3,4] then [5,6]
    bus2.send_rdy = 1'b1;
    for (int d = 3; d <= 6; d++) begin
      bus2.recv_msg = 32'(d);
      bus2.recv_val = 1'b1;
      step();
      if (d == 4) begin
        check_eq("t6_val_a", 32'(bus2.send_val), 32'd1);
        check_eq("t6_a0", bus2.send_msg[0], 32'd3);
        check_eq("t6_a1", bus2.send_msg[1], 32'd4);
      end
      if (d == 5) check_eq("t6_val_mid", 32'(bus2.send_val), 32'd0);
      if (d == 6) begin
        check_eq("t6_val_b", 32'(bus2.send_val), 32'd1);
        check_eq("t6_b0", bus2.send_msg[0], 32'd5);
        check_eq("t6_b1", bus2.send_msg[1], 32'd6);
      end
    end
    bus2.recv_val = 1'b0;
    step();
    check_eq("t6_consumed", 32'(bus2.send_val), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
